down_timer: RTL and testbench
=============================

// Module: down_timer
// PURPOSE
//   Loadable WIDTH-bit countdown timer; the down-counting counterpart of the
//   board's up-counter. Value loaded from switches, decremented once per
//   prescaled tick, expiry flagged at zero.
//   Sits between switch/key inputs and the four hex_decoder instances at top.
// PARAMETERS
//   WIDTH   16          count width (4 hex digits)
//   DIV     50000000    Clock cycles per decrement tick (1 Hz at 50 MHz); DIV>=2
//   PW      $clog2(DIV) prescaler width, derived localparam, not overridable
// PORTS
//   Clock      in   1      single clock, rising edge
//   Clear      in   1      reset, asynchronous, active-low
//   Load       in   1      sync load strobe, level-sampled each cycle
//   LoadValue  in   WIDTH  value captured on Load
//   Start      in   1      begin/resume countdown from IDLE
//   Enable     in   1      1 = run; 0 = freeze count and prescaler in RUN
//   Count      out  WIDTH  current count, registered
//   Running    out  1      1 while state == RUN
//   Done       out  1      sticky; 1 while state == DONE
//   Expired    out  1      one-cycle pulse on entry to DONE
// BEHAVIOUR
//   Reset (Clear=0, async): state=IDLE, Count=0, prescaler=0, Running=0,
//     Done=0, Expired=0.
//   States: IDLE, RUN, DONE (2-bit encoding).
//   Priority each cycle: Load > Start > tick.
//   Load (any state): Count<=LoadValue, prescaler<=0, state<=IDLE. Start in
//     the same cycle is ignored.
//   IDLE + Start: Count!=0 -> RUN, prescaler<=0; Count==0 -> DONE, Expired=1
//     next cycle.
//   RUN, Enable=1: prescaler increments; at DIV-1 it wraps to 0 and tick=1.
//   RUN, Enable=0: prescaler and Count hold; state stays RUN.
//   Tick in RUN: Count<=Count-1. If Count==1, then state<=DONE in the same
//     edge. Count reaches 0, Done=1 and Expired=1 all become visible together.
//   First decrement occurs exactly DIV enabled cycles after entering RUN.
//   Count never wraps below 0; no decrement is possible outside RUN.
//   DONE: Count holds 0; Start ignored; only Load or Clear leave DONE.
//   Start while in RUN: no effect.
//   All outputs are registered or decoded directly from state; no
//     combinational path from inputs to outputs.
//   Clear asserted mid-count: immediate return to reset values; the loaded
//     value is lost.
// STRUCTURE
//   Shared package/header: state encoding localparams (ST_IDLE=0, ST_RUN=1,
//     ST_DONE=2).
//   Sub-module tick_prescaler: DIV, Clock, Clear, Enable, Restart -> Tick.
//     Tick is a 1-cycle pulse.
//   Top-level wiring: Count[3:0]/[7:4]/[11:8]/[15:12] feed hex_decoder
//     HEX0..HEX3.
// TESTING (DIV=4 in bench)
//   1. Clear=0 then release -> Count=0, Running=0, Done=0, Expired=0.
//   2. Load 16'h0003, Start, Enable=1 -> Count 3,2,1,0 every 4 cycles.
//      Expired pulses once with Count=0; Done stays 1.
//   3. Load 16'h0005, Start; Enable=0 for 10 cycles mid-run -> Count and
//      prescaler frozen; resume yields the remaining decrements with no
//      lost or extra tick.
//   4. Load 16'h0000, Start -> DONE next cycle, Expired=1 once, Count=0.
//   5. Load 16'h1234 and Start in the same cycle -> IDLE with Count=16'h1234.
//      During RUN at 16'h0002, Load 16'h00FF -> IDLE, Count=16'h00FF,
//      Running=0.
//   6. Clear pulsed asynchronously between edges in RUN -> all outputs
//      reset immediately.
//      In DONE, Start -> no change.

Source files
------------

// File: rtl/down_timer_pkg.sv
// Shared definitions for the down_timer block: state encoding and the
// seven-segment helper used to drive the four hex digits of the count.
package down_timer_pkg;

  // Controller state encoding (2 bits)
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of hex digits presented to the display
  localparam int unsigned DIGITS = 4;

  // Active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/down_timer_tick_prescaler.sv
// Prescaler producing a one-cycle tick every DIV enabled cycles.
// Restart clears the phase so the first tick lands exactly DIV enabled
// cycles after the restart; with enable low the phase is frozen.
module tick_prescaler #(
  parameter int DIV = 50000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] presc_q;

  // Tick fires on the enabled cycle that closes a full DIV-cycle period
  assign tick_o = enable_i && !restart_i && (presc_q == LAST);

  // Phase counter: restart wins, otherwise advance only while enabled
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= '0;
    end else if (restart_i) begin
      presc_q <= '0;
    end else if (enable_i) begin
      if (presc_q == LAST) begin
        presc_q <= '0;
      end else begin
        presc_q <= presc_q + PW'(1);
      end
    end
  end

endmodule

// File: rtl/down_timer.sv
// Loadable countdown timer: value loaded from switches, decremented once per
// prescaled tick while running, with sticky done flag and a one-cycle expiry
// pulse. Also presents the count as four active-low hex digits.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIV   = 50000000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    load_i,
  input  logic [WIDTH-1:0]        load_value_i,
  input  logic                    start_i,
  input  logic                    enable_i,
  output logic [WIDTH-1:0]        count_o,
  output logic                    running_o,
  output logic                    done_o,
  output logic                    expired_o,
  output logic [DIGITS-1:0][6:0]  hex_o
);

  state_e             state_q;
  logic [WIDTH-1:0]   count_q;
  logic               running_q;
  logic               done_q;
  logic               expired_q;

  logic               tick;
  logic               presc_en;
  logic               presc_restart;
  logic [4*DIGITS-1:0] count_pad;

  // Prescaler runs only in RUN; a load or a start from IDLE resets its phase
  assign presc_en      = enable_i && (state_q == ST_RUN) && !load_i;
  assign presc_restart = load_i || ((state_q == ST_IDLE) && start_i);

  tick_prescaler #(
    .DIV(DIV)
  ) u_prescaler (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .enable_i (presc_en),
    .restart_i(presc_restart),
    .tick_o   (tick)
  );

  // Controller: load > start > tick; outputs registered alongside the state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      expired_q <= 1'b0;
      if (load_i) begin
        count_q   <= load_value_i;
        state_q   <= ST_IDLE;
        running_q <= 1'b0;
        done_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_i) begin
              if (count_q != '0) begin
                state_q   <= ST_RUN;
                running_q <= 1'b1;
              end else begin
                state_q   <= ST_DONE;
                done_q    <= 1'b1;
                expired_q <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            // Zero guard keeps the count from ever wrapping
            if (tick && (count_q != '0)) begin
              count_q <= count_q - WIDTH'(1);
              if (count_q == WIDTH'(1)) begin
                state_q   <= ST_DONE;
                running_q <= 1'b0;
                done_q    <= 1'b1;
                expired_q <= 1'b1;
              end
            end
          end
          ST_DONE: begin
            // Only load or clear leave DONE; count holds at zero
          end
          default: begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count_o   = count_q;
  assign running_o = running_q;
  assign done_o    = done_q;
  assign expired_o = expired_q;

  // Count zero-extended (or truncated) to the four displayed nibbles
  assign count_pad = (4*DIGITS)'(count_q);

  // One segment decoder per displayed nibble
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_hex
    assign hex_o[gi] = hex_to_seg(count_pad[4*gi +: 4]);
  end

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer (DIV=4): directed scenarios followed by
// randomized load/start/enable/clear traffic, all compared every cycle
// against a count-of-enabled-cycles reference model.
module tb_down_timer;

  localparam int WIDTH = 16;
  localparam int DIV   = 4;

  logic              clk;
  logic              rst_n;
  logic              load;
  logic [WIDTH-1:0]  lv;
  logic              start;
  logic              en;
  logic [WIDTH-1:0]  count_o;
  logic              running_o;
  logic              done_o;
  logic              expired_o;
  logic [3:0][6:0]   hex_o;

  down_timer #(
    .WIDTH(WIDTH),
    .DIV  (DIV)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .load_i      (load),
    .load_value_i(lv),
    .start_i     (start),
    .enable_i    (en),
    .count_o     (count_o),
    .running_o   (running_o),
    .done_o      (done_o),
    .expired_o   (expired_o),
    .hex_o       (hex_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: 0 idle, 1 run, 2 done. While running the count is the
  // start value minus whole DIV-periods of enabled cycles seen so far.
  int              m_mode;
  logic [WIDTH-1:0] m_count;
  logic [WIDTH-1:0] m_base;
  int              m_en;
  logic            m_exp;

  logic [6:0] seg_tbl [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_count = '0;
    m_base  = '0;
    m_en    = 0;
    m_exp   = 1'b0;
  endtask

  task automatic model_step();
    m_exp = 1'b0;
    if (load) begin
      m_mode  = 0;
      m_count = lv;
    end else if (m_mode == 0) begin
      if (start) begin
        if (m_count != 0) begin
          m_mode = 1;
          m_base = m_count;
          m_en   = 0;
        end else begin
          m_mode = 2;
          m_exp  = 1'b1;
        end
      end
    end else if (m_mode == 1) begin
      if (en) begin
        m_en++;
        m_count = m_base - WIDTH'(m_en / DIV);
        if (m_count == 0) begin
          m_mode = 2;
          m_exp  = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("count",   32'(count_o),   32'(m_count));
    chk("running", 32'(running_o), 32'(m_mode == 1));
    chk("done",    32'(done_o),    32'(m_mode == 2));
    chk("expired", 32'(expired_o), 32'(m_exp));
    for (int d = 0; d < 4; d++) begin
      chk("hex", 32'(hex_o[d]), 32'(seg_tbl[m_count[4*d +: 4]]));
    end
  endtask

  // One clock: model follows the inputs the DUT sampled, outputs checked mid-cycle
  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check_all();
  endtask

  // Assert clear between edges; outputs must drop before the next edge
  task automatic async_clear();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int pulses;
  int steps;

  initial begin
    seg_tbl[0]  = 7'b1000000; seg_tbl[1]  = 7'b1111001;
    seg_tbl[2]  = 7'b0100100; seg_tbl[3]  = 7'b0110000;
    seg_tbl[4]  = 7'b0011001; seg_tbl[5]  = 7'b0010010;
    seg_tbl[6]  = 7'b0000010; seg_tbl[7]  = 7'b1111000;
    seg_tbl[8]  = 7'b0000000; seg_tbl[9]  = 7'b0010000;
    seg_tbl[10] = 7'b0001000; seg_tbl[11] = 7'b0000011;
    seg_tbl[12] = 7'b1000110; seg_tbl[13] = 7'b0100001;
    seg_tbl[14] = 7'b0000110; seg_tbl[15] = 7'b0001110;

    rst_n = 1'b1; load = 1'b0; lv = '0; start = 1'b0; en = 1'b0;
    model_reset();

    // 1. reset
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    cycle();
    $display("scenario 1 reset: count=%h running=%b done=%b", count_o, running_o, done_o);

    // 2. count 3 down to 0
    load = 1'b1; lv = 16'h0003; cycle();
    load = 1'b0; start = 1'b1; en = 1'b1; cycle();
    start = 1'b0;
    pulses = 0;
    repeat (16) begin
      cycle();
      if (expired_o) pulses++;
    end
    chk("t2_pulses", 32'(pulses), 32'd1);
    chk("t2_done", 32'(done_o), 32'd1);
    $display("scenario 2 countdown from 3: count=%h done=%b pulses=%0d", count_o, done_o, pulses);

    // 3. freeze mid-run then resume
    load = 1'b1; lv = 16'h0005; cycle();
    load = 1'b0; start = 1'b1; en = 1'b1; cycle();
    start = 1'b0;
    repeat (6) cycle();
    en = 1'b0;
    repeat (10) cycle();
    chk("t3_frozen", 32'(count_o), 32'd4);
    en = 1'b1;
    repeat (20) cycle();
    chk("t3_done", 32'(done_o), 32'd1);
    $display("scenario 3 freeze/resume: count=%h done=%b", count_o, done_o);

    // 4. start with zero count
    load = 1'b1; lv = 16'h0000; cycle();
    load = 1'b0; start = 1'b1; cycle();
    start = 1'b0;
    chk("t4_expired", 32'(expired_o), 32'd1);
    repeat (3) cycle();
    $display("scenario 4 zero start: done=%b", done_o);

    // 5. load beats start; load during run
    load = 1'b1; start = 1'b1; lv = 16'h1234; cycle();
    load = 1'b0; start = 1'b0;
    chk("t5_count", 32'(count_o), 32'h1234);
    chk("t5_running", 32'(running_o), 32'd0);
    load = 1'b1; lv = 16'h0003; cycle();
    load = 1'b0; start = 1'b1; en = 1'b1; cycle();
    start = 1'b0;
    steps = 0;
    while (count_o != 16'h0002 && steps < 40) begin
      cycle();
      steps++;
    end
    chk("t5_reach2", 32'(count_o), 32'h0002);
    load = 1'b1; lv = 16'h00FF; cycle();
    load = 1'b0;
    chk("t5_reload", 32'(count_o), 32'h00FF);
    chk("t5_idle", 32'(running_o), 32'd0);
    repeat (3) cycle();
    $display("scenario 5 load priority: count=%h running=%b", count_o, running_o);

    // 6. async clear mid-run; start ignored in DONE
    load = 1'b1; lv = 16'h0007; cycle();
    load = 1'b0; start = 1'b1; en = 1'b1; cycle();
    start = 1'b0;
    repeat (5) cycle();
    async_clear();
    chk("t6_cleared", 32'(count_o), 32'd0);
    cycle();
    load = 1'b1; lv = 16'h0000; cycle();
    load = 1'b0; start = 1'b1; cycle();
    repeat (3) cycle();
    start = 1'b0;
    chk("t6_done_hold", 32'(done_o), 32'd1);
    $display("scenario 6 clear/done: count=%h done=%b", count_o, done_o);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      load  = ($urandom_range(0, 15) == 0);
      lv    = ($urandom_range(0, 7) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 6));
      start = ($urandom_range(0, 3) == 0);
      en    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) begin
        async_clear();
      end
      cycle();
    end
    $display("random phase: count=%h state running=%b done=%b", count_o, running_o, done_o);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
